// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU/mux selects,
// FSM state codes and the packed control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef logic [3:0] state_t;

    localparam state_t StRst    = 4'd0;
    localparam state_t StFetch  = 4'd1;
    localparam state_t StDecode = 4'd2;
    localparam state_t StMemAdr = 4'd3;
    localparam state_t StMemRd  = 4'd4;
    localparam state_t StMemWb  = 4'd5;
    localparam state_t StMemWr  = 4'd6;
    localparam state_t StExec   = 4'd7;
    localparam state_t StAluWb  = 4'd8;
    localparam state_t StBranch = 4'd9;
    localparam state_t StJump   = 4'd10;
    localparam state_t StAddiEx = 4'd11;
    localparam state_t StAddiWb = 4'd12;
    localparam state_t StHalt   = 4'd13;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal_op(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the main-control FSM (master) and the datapath (slave).
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pcwrite;
    logic             pcwritecond;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic [1:0]       pcsrc;
    logic             instr_done;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
               regwrite, alusrca, alusrcb, aluop, pcsrc, instr_done, halted, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
               regwrite, alusrca, alusrcb, aluop, pcsrc, instr_done, halted, retired
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// State -> control-word decode. Only the FETCH/MEMWR handshake qualifiers and the
// skipped-illegal retire pulse look at anything besides the state.
module mc_ctrl_outdec
    import mips_pkg::*;
#(
    parameter bit HALT_ILL = 1'b1
) (
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Every field defaults to 0; each state raises only its own controls.
    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.memread = 1'b1;
                // PC/IR load only on the completing cycle, so waits never double-increment.
                ctrl_o.irwrite = mem_ready_i;
                ctrl_o.pcwrite = mem_ready_i;
                ctrl_o.alusrcb = ALUSRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                ctrl_o.pcsrc   = PCSRC_ALU;
            end
            StDecode: begin
                ctrl_o.alusrcb    = ALUSRCB_IMMSH;
                ctrl_o.aluop      = ALUOP_ADD;
                ctrl_o.instr_done = !HALT_ILL && !is_legal_op(opcode_i);
            end
            StMemAdr, StAddiEx: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            StMemRd: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            StMemWb: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.memtoreg   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StMemWr: begin
                ctrl_o.memwrite   = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            StExec: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_RT;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            StAluWb: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.regdst     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StBranch: begin
                ctrl_o.alusrca     = 1'b1;
                ctrl_o.alusrcb     = ALUSRCB_RT;
                ctrl_o.aluop       = ALUOP_SUB;
                ctrl_o.pcwritecond = 1'b1;
                ctrl_o.pcsrc       = PCSRC_ALUOUT;
                ctrl_o.instr_done  = 1'b1;
            end
            StJump: begin
                ctrl_o.pcwrite    = 1'b1;
                ctrl_o.pcsrc      = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            StAddiWb: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            StHalt: ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: state register, next-state logic, retired counter.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter bit          HALT_ILL = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    mc_control_fsm_if.master  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctrl;

    mc_ctrl_outdec #(
        .HALT_ILL(HALT_ILL)
    ) u_outdec (
        .state_i    (state_q),
        .opcode_i   (bus.opcode),
        .mem_ready_i(bus.mem_ready),
        .ctrl_o     (ctrl)
    );

    // Next state; opcode matters only in DECODE and for the lw/sw split in MEMADR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst:    state_d = StFetch;
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
                    OP_ADDI:      state_d = StAddiEx;
                    default:      state_d = HALT_ILL ? StHalt : StFetch;
                endcase
            end
            StMemAdr: state_d = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWr:  if (bus.mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StBranch, StJump, StAddiWb: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StRst;
        endcase
    end

    // Retire on the same edge that ends the instruction; wraps naturally.
    always_comb begin
        retired_d = retired_q + CNT_W'(ctrl.instr_done);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRst;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Drive the bundle from the decoded control word.
    always_comb begin
        bus.pcwrite     = ctrl.pcwrite;
        bus.pcwritecond = ctrl.pcwritecond;
        bus.iord        = ctrl.iord;
        bus.memread     = ctrl.memread;
        bus.memwrite    = ctrl.memwrite;
        bus.irwrite     = ctrl.irwrite;
        bus.memtoreg    = ctrl.memtoreg;
        bus.regdst      = ctrl.regdst;
        bus.regwrite    = ctrl.regwrite;
        bus.alusrca     = ctrl.alusrca;
        bus.alusrcb     = ctrl.alusrcb;
        bus.aluop       = ctrl.aluop;
        bus.pcsrc       = ctrl.pcsrc;
        bus.instr_done  = ctrl.instr_done;
        bus.halted      = ctrl.halted;
        bus.retired     = retired_q;
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (halting/32-bit and skipping/4-bit counter)
// driven in lockstep and compared each cycle against a phase-schedule model.
module tb_mc_control_fsm;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

    localparam int PH_RST = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3, PH_MEMRD = 4;
    localparam int PH_MEMWB = 5, PH_MEMWR = 6, PH_EXEC = 7, PH_ALUWB = 8, PH_BRANCH = 9;
    localparam int PH_JUMP = 10, PH_ADDIEX = 11, PH_ADDIWB = 12, PH_HALT = 13;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(32)) bus_a ();
    mc_control_fsm_if #(.CNT_W(4))  bus_b ();

    mc_control_fsm #(.CNT_W(32), .HALT_ILL(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    mc_control_fsm #(.CNT_W(4), .HALT_ILL(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    logic [18:0] obs_a, obs_b;
    assign obs_a = {bus_a.pcwrite, bus_a.pcwritecond, bus_a.iord, bus_a.memread,
                    bus_a.memwrite, bus_a.irwrite, bus_a.memtoreg, bus_a.regdst,
                    bus_a.regwrite, bus_a.alusrca, bus_a.alusrcb, bus_a.aluop, bus_a.pcsrc,
                    bus_a.instr_done, bus_a.halted};
    assign obs_b = {bus_b.pcwrite, bus_b.pcwritecond, bus_b.iord, bus_b.memread,
                    bus_b.memwrite, bus_b.irwrite, bus_b.memtoreg, bus_b.regdst,
                    bus_b.regwrite, bus_b.alusrca, bus_b.alusrcb, bus_b.aluop, bus_b.pcsrc,
                    bus_b.instr_done, bus_b.halted};

    int          checks = 0;
    int          fails = 0;
    int unsigned cnt_a = 0;
    int unsigned cnt_b = 0;

    // Expected control word for a phase, written straight from the control table.
    function automatic logic [18:0] ew(int ph, bit rdy, bit ill_skip);
        logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0;
        logic asa = 0, done = 0, hlt = 0;
        logic [1:0] asb = 2'b00, aop = 2'b00, ps = 2'b00;
        case (ph)
            PH_FETCH:  begin mr = 1; irw = rdy; pw = rdy; asb = 2'b01; end
            PH_DECODE: begin asb = 2'b11; done = ill_skip; end
            PH_MEMADR, PH_ADDIEX: begin asa = 1; asb = 2'b10; end
            PH_MEMRD:  begin mr = 1; io = 1; end
            PH_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
            PH_MEMWR:  begin mw = 1; io = 1; done = rdy; end
            PH_EXEC:   begin asa = 1; aop = 2'b10; end
            PH_ALUWB:  begin rw = 1; rd = 1; done = 1; end
            PH_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
            PH_JUMP:   begin pw = 1; ps = 2'b10; done = 1; end
            PH_ADDIWB: begin rw = 1; done = 1; end
            PH_HALT:   hlt = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, done, hlt};
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    // One clock cycle: drive, check at negedge, clock, advance retire counts.
    task automatic run_cycle(input int ph_a, input int ph_b, input logic [5:0] op,
                             input bit rdy, input bit ill_b);
        logic [18:0] ea, eb;
        ea = ew(ph_a, rdy, 1'b0);
        eb = ew(ph_b, rdy, ill_b);
        bus_a.opcode = op; bus_b.opcode = op;
        bus_a.mem_ready = rdy; bus_b.mem_ready = rdy;
        @(negedge clk);
        checks++;
        if (obs_a !== ea) begin
            fails++;
            $display("FAIL ctrl_a phase=%0d: got %b expected %b", ph_a, obs_a, ea);
        end
        checks++;
        if (obs_b !== eb) begin
            fails++;
            $display("FAIL ctrl_b phase=%0d: got %b expected %b", ph_b, obs_b, eb);
        end
        checks++;
        if (bus_a.retired !== cnt_a) begin
            fails++;
            $display("FAIL retired_a: got %0d expected %0d", bus_a.retired, cnt_a);
        end
        checks++;
        if (bus_b.retired !== 4'(cnt_b)) begin
            fails++;
            $display("FAIL retired_b: got %0d expected %0d", bus_b.retired, cnt_b);
        end
        @(posedge clk);
        if (ea[1]) cnt_a++;
        if (eb[1]) cnt_b = (cnt_b + 1) % 16;
        #1;
    endtask

    // Full legal instruction from FETCH; inputs outside DECODE/MEMADR are random junk.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit a_halted);
        int h;
        for (int i = 0; i < fw; i++) begin
            h = a_halted ? PH_HALT : PH_FETCH;
            run_cycle(h, PH_FETCH, junk(), 1'b0, 1'b0);
        end
        run_cycle(a_halted ? PH_HALT : PH_FETCH, PH_FETCH, junk(), 1'b1, 1'b0);
        run_cycle(a_halted ? PH_HALT : PH_DECODE, PH_DECODE, op, 1'($urandom), 1'b0);
        case (op)
            LW, SW: begin
                run_cycle(a_halted ? PH_HALT : PH_MEMADR, PH_MEMADR, op, 1'($urandom), 1'b0);
                h = (op == LW) ? PH_MEMRD : PH_MEMWR;
                for (int i = 0; i < mw; i++)
                    run_cycle(a_halted ? PH_HALT : h, h, junk(), 1'b0, 1'b0);
                run_cycle(a_halted ? PH_HALT : h, h, junk(), 1'b1, 1'b0);
                if (op == LW)
                    run_cycle(a_halted ? PH_HALT : PH_MEMWB, PH_MEMWB, junk(), 1'($urandom),
                              1'b0);
            end
            RT: begin
                run_cycle(a_halted ? PH_HALT : PH_EXEC, PH_EXEC, junk(), 1'($urandom), 1'b0);
                run_cycle(a_halted ? PH_HALT : PH_ALUWB, PH_ALUWB, junk(), 1'($urandom), 1'b0);
            end
            BEQ: run_cycle(a_halted ? PH_HALT : PH_BRANCH, PH_BRANCH, junk(), 1'($urandom),
                           1'b0);
            JMP: run_cycle(a_halted ? PH_HALT : PH_JUMP, PH_JUMP, junk(), 1'($urandom), 1'b0);
            default: begin
                run_cycle(a_halted ? PH_HALT : PH_ADDIEX, PH_ADDIEX, junk(), 1'($urandom),
                          1'b0);
                run_cycle(a_halted ? PH_HALT : PH_ADDIWB, PH_ADDIWB, junk(), 1'($urandom),
                          1'b0);
            end
        endcase
    endtask

    function automatic logic [5:0] rand_legal();
        logic [5:0] ops [6];
        ops = '{LW, SW, RT, BEQ, JMP, ADDI};
        return ops[$urandom_range(0, 5)];
    endfunction

    // Asynchronous reset between clock edges: everything must clear without an edge.
    task automatic async_reset_and_restart();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs_a !== '0 || bus_a.retired !== '0) begin
            fails++;
            $display("FAIL async_reset_a: got %b/%0d expected 0/0", obs_a, bus_a.retired);
        end
        checks++;
        if (obs_b !== '0 || bus_b.retired !== '0) begin
            fails++;
            $display("FAIL async_reset_b: got %b/%0d expected 0/0", obs_b, bus_b.retired);
        end
        cnt_a = 0; cnt_b = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_cycle(PH_RST, PH_RST, junk(), 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        bus_a.opcode = '0; bus_b.opcode = '0;
        bus_a.mem_ready = 1'b0; bus_b.mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        checks++;
        if (obs_a !== '0 || obs_b !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b/%b expected all zero", obs_a, obs_b);
        end
        reset_n = 1'b1;
        run_cycle(PH_RST, PH_RST, junk(), 1'b0, 1'b0);
    endtask

    task automatic test_lw();
        run_instr(LW, 0, 0, 1'b0);
        checks++;
        if (bus_a.retired !== 32'd1) begin
            fails++;
            $display("FAIL lw_retired: got %0d expected 1", bus_a.retired);
        end
    endtask

    task automatic test_rtype();
        run_instr(RT, 0, 0, 1'b0);
    endtask

    task automatic test_sw_wait();
        run_instr(SW, 0, 3, 1'b0);
    endtask

    task automatic test_branch_jump();
        run_instr(BEQ, 0, 0, 1'b0);
        run_instr(JMP, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    endtask

    task automatic test_reset_mid_access();
        run_cycle(PH_FETCH, PH_FETCH, junk(), 1'b1, 1'b0);
        run_cycle(PH_DECODE, PH_DECODE, LW, 1'b1, 1'b0);
        run_cycle(PH_MEMADR, PH_MEMADR, LW, 1'b1, 1'b0);
        run_cycle(PH_MEMRD, PH_MEMRD, junk(), 1'b0, 1'b0);
        bus_a.mem_ready = 1'b0; bus_b.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus_a.memread !== 1'b1 || bus_b.memread !== 1'b1) begin
            fails++;
            $display("FAIL memrd_wait: got %b/%b expected 1/1", bus_a.memread, bus_b.memread);
        end
        async_reset_and_restart();
        run_instr(LW, 0, 1, 1'b0);
    endtask

    task automatic test_wrap();
        async_reset_and_restart();
        for (int n = 0; n < 17; n++) run_instr(ADDI, 0, 0, 1'b0);
        checks++;
        if (bus_b.retired !== 4'd1 || bus_a.retired !== 32'd17) begin
            fails++;
            $display("FAIL wrap: got %0d/%0d expected 1/17", bus_b.retired, bus_a.retired);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] bad;
        bad = 6'b111111;
        if ($urandom_range(0, 1) == 1) begin
            do bad = junk(); while (bad inside {LW, SW, RT, BEQ, JMP, ADDI});
        end
        run_cycle(PH_FETCH, PH_FETCH, junk(), 1'b1, 1'b0);
        run_cycle(PH_DECODE, PH_DECODE, bad, 1'b1, 1'b1);
        for (int n = 0; n < 6; n++)
            run_instr(rand_legal(), $urandom_range(0, 1), $urandom_range(0, 2), 1'b1);
        async_reset_and_restart();
        run_instr(LW, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_wait();
        test_branch_jump();
        test_random();
        test_reset_mid_access();
        test_wrap();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
